// File: rtl/reg_file_mp_pkg.sv
// Shared types and defaults for the multi-port register file.
// Build option: REGFILE_BYPASS_EN enables write-to-read forwarding.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } state_t;

   function automatic int aw(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/write-back side bundle of the register file.
// master = pipeline, slave = register file.
interface reg_file_mp_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5,
   parameter int NRD  = 2
);

   logic                 RegWrite;
   logic [AW-1:0]        Rd;
   logic [XLEN-1:0]      Write_data;
   logic [NRD*AW-1:0]    Rs;
   logic [NRD*XLEN-1:0]  read_data;
   logic [NRD-1:0]       rs_pending;
   logic                 sb_set;
   logic [AW-1:0]        sb_rd;
   logic                 ready;

   modport master (
      output RegWrite, Rd, Write_data, Rs,
      output sb_set, sb_rd,
      input  read_data, rs_pending, ready
   );

   modport slave (
      input  RegWrite, Rd, Write_data, Rs,
      input  sb_set, sb_rd,
      output read_data, rs_pending, ready
   );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Pending-write bit per register with set priority over clear.
// Build option: REGFILE_BYPASS_EN (handled in the top).
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int AW    = aw(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_en,
   input  logic [AW-1:0]     set_idx,
   input  logic              clr_en,
   input  logic [AW-1:0]     clr_idx,
   input  logic [NRD*AW-1:0] rd_idx,
   output logic [NRD-1:0]    rd_bits
);

   logic [NREGS-1:0] sb;
   logic [NREGS-1:0] set_m;
   logic [NREGS-1:0] clr_m;

   always_comb begin
      set_m = '0;
      clr_m = '0;
      if (set_en) set_m[set_idx] = 1'b1;
      if (clr_en) clr_m[clr_idx] = 1'b1;
   end

   // A younger producer outranks the retiring one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sb <= '0;
      else      sb <= (sb & ~clr_m) | set_m;
   end

   always_comb begin
      rd_bits = '0;
      for (int i = 0; i < NRD; i++)
         rd_bits[i] = sb[rd_idx[i*AW +: AW]];
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with scoreboard and post-reset clear sweep.
// Build option: REGFILE_BYPASS_EN forwards same-cycle writes to readers.
module reg_file_mp
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int NRD    = 2,
   parameter int ZERO_R = 1
) (
   input  logic         clk,
   input  logic         rst,
   reg_file_mp_if.slave bus
);

   localparam int AW = aw(NREGS);
   localparam bit ZR = (ZERO_R != 0);

   state_t state;
   state_t state_nx;

   logic [AW:0]      clr_idx;
   logic             sweep_last;
   logic             ready;
   logic             wr_en;
   logic             set_en;
   logic [NRD-1:0]   sb_bits;
   logic [XLEN-1:0]  mem [NREGS];

   logic [NRD*XLEN-1:0] rd_all;
   logic [NRD-1:0]      pend_all;

   assign sweep_last = (clr_idx == (AW+1)'(NREGS-1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_CLEAR;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_CLEAR: if (sweep_last) state_nx = ST_READY;
         ST_READY: state_nx = ST_READY;
      endcase
   end

   always_comb begin
      ready  = (state == ST_READY);
      wr_en  = ready && bus.RegWrite
             && !(ZR && bus.Rd == '0);
      set_en = ready && bus.sb_set
             && !(ZR && bus.sb_rd == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         clr_idx <= '0;
      else if (state == ST_CLEAR && !sweep_last)
         clr_idx <= clr_idx + 1'b1;
   end

   // No reset on storage so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR)
         mem[clr_idx[AW-1:0]] <= '0;
      else if (wr_en)
         mem[bus.Rd] <= bus.Write_data;
   end

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD),
      .AW    (AW)
   ) u_sb (
      .clk     (clk),
      .rst     (rst),
      .set_en  (set_en),
      .set_idx (bus.sb_rd),
      .clr_en  (wr_en),
      .clr_idx (bus.Rd),
      .rd_idx  (bus.Rs),
      .rd_bits (sb_bits)
   );

   always_comb begin
      rd_all   = '0;
      pend_all = '0;
      for (int i = 0; i < NRD; i++) begin
         rd_all[i*XLEN +: XLEN] = mem[bus.Rs[i*AW +: AW]];
         pend_all[i]            = sb_bits[i];
`ifdef REGFILE_BYPASS_EN
         if (wr_en && bus.Rs[i*AW +: AW] == bus.Rd) begin
            rd_all[i*XLEN +: XLEN] = bus.Write_data;
            pend_all[i]            = 1'b0;
         end
`endif
         if (ZR && bus.Rs[i*AW +: AW] == '0) begin
            rd_all[i*XLEN +: XLEN] = '0;
            pend_all[i]            = 1'b0;
         end
      end
   end

   assign bus.read_data  = rd_all;
   assign bus.rs_pending = pend_all;
   assign bus.ready      = ready;

endmodule
